reg_read_issue_ctrl: RTL and testbench

//  Parametrised successor to the ID-stage read-register select: N read ports, each picking rs/rt/rd/zero.

---
 rtl/cpu_reg_pkg.sv | 19 +
 rtl/reg_scoreboard.sv | 57 +++++
 rtl/reg_read_issue_ctrl.sv | 122 ++++++++++++
 tb/tb_reg_read_issue_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_reg_pkg.sv
// cpu_reg_pkg -- shared constants and types for the ID-stage read-register issue logic.
// Rev 1.0
`default_nettype none

package cpu_reg_pkg;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int REG_SEL_W      = 2;

  typedef enum logic [REG_SEL_W-1:0] {
    SRC_RS   = 2'd0,
    SRC_RT   = 2'd1,
    SRC_RD   = 2'd2,
    SRC_ZERO = 2'd3
  } reg_sel_t;

endpackage

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// reg_scoreboard -- busy-bit array with set-wins priority, r0 masking and RAW hazard lookup.
// Rev 1.0; WB_BYPASS_EN lets a register being written back this cycle read as not busy.
`default_nettype none

module reg_scoreboard
  import cpu_reg_pkg::*;
#(
  parameter int NUM_RD_PORTS = 2,
  parameter int REG_ADDR_W   = DEF_REG_ADDR_W
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               set_en,
  input  logic [REG_ADDR_W-1:0]              set_reg,
  input  logic                               wb_clr_en,
  input  logic [REG_ADDR_W-1:0]              wb_clr_reg,
  input  logic                               flush_clr_en,
  input  logic [REG_ADDR_W-1:0]              flush_clr_reg,
  input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] rd_addr,
  output logic                               hazard
);

  localparam int NUM_REGS = 2**REG_ADDR_W;

  logic [NUM_REGS-1:0]     busy_q;
  logic [NUM_REGS-1:0]     busy_d;
  logic [NUM_RD_PORTS-1:0] port_hz;

  // Set is applied last so a new producer outranks a same-cycle retire.
  always_comb begin
    busy_d = busy_q;
    if (wb_clr_en)    busy_d[wb_clr_reg]    = 1'b0;
    if (flush_clr_en) busy_d[flush_clr_reg] = 1'b0;
    if (set_en)       busy_d[set_reg]       = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_lookup
    logic [REG_ADDR_W-1:0] addr;
    assign addr = rd_addr[p*REG_ADDR_W +: REG_ADDR_W];
`ifdef WB_BYPASS_EN
    assign port_hz[p] = busy_q[addr] && (addr != '0) && !(wb_clr_en && (wb_clr_reg == addr));
`else
    assign port_hz[p] = busy_q[addr] && (addr != '0);
`endif
  end

  assign hazard = |port_hz;

endmodule

`default_nettype wire

// File: rtl/reg_read_issue_ctrl.sv
// reg_read_issue_ctrl -- per-port read select, RAW stall, ID->EX handshake and stall counter.
// Rev 1.0; optional WB_BYPASS_EN (same-cycle writeback removes the hazard).
`default_nettype none

module reg_read_issue_ctrl
  import cpu_reg_pkg::*;
#(
  parameter int NUM_RD_PORTS = 2,
  parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
  parameter int SEL_W        = REG_SEL_W,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [REG_ADDR_W-1:0]              rs_id,
  input  logic [REG_ADDR_W-1:0]              rt_id,
  input  logic [REG_ADDR_W-1:0]              rd_id,
  input  logic [NUM_RD_PORTS*SEL_W-1:0]      sel_id,
  input  logic [REG_ADDR_W-1:0]              dest_id,
  input  logic                               wr_en_id,
  input  logic                               id_valid,
  output logic                               id_ready,
  input  logic                               ex_ready,
  output logic                               ex_valid,
  input  logic                               flush,
  input  logic                               wb_valid,
  input  logic [REG_ADDR_W-1:0]              wb_reg,
  output logic [NUM_RD_PORTS*REG_ADDR_W-1:0] r_addr,
  output logic [NUM_RD_PORTS*REG_ADDR_W-1:0] ex_raddr,
  output logic [STALL_CNT_W-1:0]             stall_cnt
);

  logic                               hazard;
  logic                               fire;
  logic                               ex_valid_q, ex_valid_d;
  logic                               ex_wr_q, ex_wr_d;
  logic [REG_ADDR_W-1:0]              ex_dest_q, ex_dest_d;
  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] ex_raddr_q, ex_raddr_d;
  logic [STALL_CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    reg_sel_t              src;
    logic [REG_ADDR_W-1:0] addr;
    assign src = reg_sel_t'(sel_id[p*SEL_W +: REG_SEL_W]);
    always_comb begin
      addr = '0;
      case (src)
        SRC_RS:   addr = rs_id;
        SRC_RT:   addr = rt_id;
        SRC_RD:   addr = rd_id;
        SRC_ZERO: addr = '0;
      endcase
    end
    assign r_addr[p*REG_ADDR_W +: REG_ADDR_W] = addr;
  end

  reg_scoreboard #(
    .NUM_RD_PORTS (NUM_RD_PORTS),
    .REG_ADDR_W   (REG_ADDR_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .set_en        (fire && wr_en_id && (dest_id != '0)),
    .set_reg       (dest_id),
    .wb_clr_en     (wb_valid),
    .wb_clr_reg    (wb_reg),
    .flush_clr_en  (flush && ex_valid_q && ex_wr_q),
    .flush_clr_reg (ex_dest_q),
    .rd_addr       (r_addr),
    .hazard        (hazard)
  );

  assign id_ready = !hazard && (ex_ready || !ex_valid_q) && !flush;
  assign fire     = id_valid && id_ready;

  // Flush outranks everything; fire cannot coincide because id_ready is low.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_wr_d    = ex_wr_q;
    ex_dest_d  = ex_dest_q;
    ex_raddr_d = ex_raddr_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (fire) begin
      ex_valid_d = 1'b1;
      ex_wr_d    = wr_en_id && (dest_id != '0);
      ex_dest_d  = dest_id;
      ex_raddr_d = r_addr;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_valid && hazard && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_wr_q     <= 1'b0;
      ex_dest_q   <= '0;
      ex_raddr_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_wr_q     <= ex_wr_d;
      ex_dest_q   <= ex_dest_d;
      ex_raddr_q  <= ex_raddr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_raddr  = ex_raddr_q;
  assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_read_issue_ctrl.sv
// tb_reg_read_issue_ctrl -- scoreboard bench for reg_read_issue_ctrl (default 2 ports, 5-bit regs).
// Rev 1.0
`default_nettype none

module tb_reg_read_issue_ctrl;

  localparam int NP = 2;
  localparam int AW = 5;
  localparam int SW = 2;
  localparam int CW = 16;
`ifdef WB_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic              clk, rst_n;
  logic [AW-1:0]     rs_id, rt_id, rd_id, dest_id, wb_reg;
  logic [NP*SW-1:0]  sel_id;
  logic              wr_en_id, id_valid, id_ready, ex_ready, ex_valid, flush, wb_valid;
  logic [NP*AW-1:0]  r_addr, ex_raddr;
  logic [CW-1:0]     stall_cnt;

  logic [NP*AW-1:0]  exp_q[$];
  int                n_checks = 0;
  int                n_errors = 0;
  int                exp_stall = 0;
  int                stalls, cnt_wb;
  logic [NP*AW-1:0]  held;

  reg_read_issue_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs_id     (rs_id),
    .rt_id     (rt_id),
    .rd_id     (rd_id),
    .sel_id    (sel_id),
    .dest_id   (dest_id),
    .wr_en_id  (wr_en_id),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .ex_ready  (ex_ready),
    .ex_valid  (ex_valid),
    .flush     (flush),
    .wb_valid  (wb_valid),
    .wb_reg    (wb_reg),
    .r_addr    (r_addr),
    .ex_raddr  (ex_raddr),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] src_model(input logic [1:0] s, input logic [AW-1:0] a,
                                               input logic [AW-1:0] b, input logic [AW-1:0] c);
    case (s)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return '0;
    endcase
  endfunction

  // Presents one instruction and waits for it to fire; wb pulse at cycle wb_at (-1 = none).
  task automatic issue(input logic [NP*SW-1:0] sel, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] rd, input logic [AW-1:0] dest, input logic wr,
                       input int wb_at, input logic [AW-1:0] wb_r,
                       output int n_stall, output int cnt_at_wb);
    logic [NP*AW-1:0] exp;
    logic [NP*AW-1:0] popped;
    sel_id = sel; rs_id = rs; rt_id = rt; rd_id = rd; dest_id = dest; wr_en_id = wr;
    id_valid = 1'b1;
    exp = {src_model(sel[3:2], rs, rt, rd), src_model(sel[1:0], rs, rt, rd)};
    exp_q.push_back(exp);
    n_stall = 0;
    cnt_at_wb = -1;
    for (int c = 0; c < 20; c++) begin
      if (c == wb_at) begin wb_valid = 1'b1; wb_reg = wb_r; end
      else wb_valid = 1'b0;
      #1;
      if (c == wb_at) cnt_at_wb = int'(stall_cnt);
      if (id_ready) begin
        check_val("r_addr", 32'(r_addr), 32'(exp));
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        check_val("ex_valid_after_fire", 32'(ex_valid), 32'd1);
        if (exp_q.size() == 0) begin
          check_val("queue_empty", 32'd0, 32'd1);
        end else begin
          popped = exp_q.pop_front();
          check_val("ex_raddr", 32'(ex_raddr), 32'(popped));
        end
        @(negedge clk);
        id_valid = 1'b0;
        wr_en_id = 1'b0;
        return;
      end
      n_stall++;
      @(negedge clk);
    end
    id_valid = 1'b0;
    wr_en_id = 1'b0;
    wb_valid = 1'b0;
    void'(exp_q.pop_back());
    check_val("issue_timeout", 32'd0, 32'd1);
    n_stall = -1;
  endtask

  initial begin
    rst_n = 1'b0; rs_id = '0; rt_id = '0; rd_id = '0; dest_id = '0; wb_reg = '0;
    sel_id = '0; wr_en_id = 1'b0; id_valid = 1'b0; ex_ready = 1'b1; flush = 1'b0; wb_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_ex_valid", 32'(ex_valid), 32'd0);
    check_val("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check_val("rst_ex_raddr", 32'(ex_raddr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Source select: port0 picks s, port1 picks 3-s.
    for (int s = 0; s < 4; s++) begin
      issue({2'(3 - s), 2'(s)}, 5'd3, 5'd7, 5'd9, 5'd0, 1'b0, -1, 5'd0, stalls, cnt_wb);
      check_val("mux_no_stall", 32'(stalls), 32'd0);
    end

    // RAW on r5, writeback after 4 stall cycles.
    issue(4'b1111, 5'd1, 5'd1, 5'd1, 5'd5, 1'b1, -1, 5'd0, stalls, cnt_wb);
    issue(4'b0000, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 4, 5'd5, stalls, cnt_wb);
    check_val("raw_cnt_at_wb", 32'(cnt_wb), 32'd4);
    check_val("raw_stalls", 32'(stalls), 32'(BYP ? 4 : 5));
    exp_stall += stalls;
    check_val("raw_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

    // Set wins over same-cycle writeback of r8.
    issue(4'b1111, 5'd0, 5'd0, 5'd0, 5'd8, 1'b1, 0, 5'd8, stalls, cnt_wb);
    issue(4'b0101, 5'd2, 5'd8, 5'd0, 5'd0, 1'b0, 2, 5'd8, stalls, cnt_wb);
    check_val("setwins_stalls", 32'(stalls), 32'(BYP ? 2 : 3));
    exp_stall += stalls;

    // Flush the r4 producer while it sits in EX.
    issue(4'b1111, 5'd0, 5'd0, 5'd0, 5'd4, 1'b1, -1, 5'd0, stalls, cnt_wb);
    flush = 1'b1;
    #1;
    check_val("flush_id_ready", 32'(id_ready), 32'd0);
    @(posedge clk);
    #1;
    check_val("flush_ex_valid", 32'(ex_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    issue(4'b1110, 5'd0, 5'd0, 5'd4, 5'd0, 1'b0, -1, 5'd0, stalls, cnt_wb);
    check_val("flush_reader_stalls", 32'(stalls), 32'd0);

    // EX backpressure holds contents and blocks issue.
    issue(4'b0100, 5'd11, 5'd12, 5'd0, 5'd0, 1'b0, -1, 5'd0, stalls, cnt_wb);
    held = {5'd12, 5'd11};
    ex_ready = 1'b0;
    sel_id = 4'b0001; rs_id = 5'd13; rt_id = 5'd14; id_valid = 1'b1;
    #1;
    check_val("bp_id_ready", 32'(id_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_val("bp_ex_valid", 32'(ex_valid), 32'd1);
    check_val("bp_ex_raddr", 32'(ex_raddr), 32'(held));
    @(negedge clk);
    ex_ready = 1'b1;
    issue(4'b0001, 5'd13, 5'd14, 5'd0, 5'd0, 1'b0, -1, 5'd0, stalls, cnt_wb);
    check_val("bp_release_stalls", 32'(stalls), 32'd0);

    // Writes to r0 never create a hazard.
    issue(4'b1111, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, -1, 5'd0, stalls, cnt_wb);
    issue(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, -1, 5'd0, stalls, cnt_wb);
    check_val("r0_stalls", 32'(stalls), 32'd0);
    check_val("stall_cnt_total", 32'(stall_cnt), 32'(exp_stall));

    // Reset in the middle of a hazard stall.
    issue(4'b1111, 5'd0, 5'd0, 5'd0, 5'd6, 1'b1, -1, 5'd0, stalls, cnt_wb);
    sel_id = 4'b1100; rs_id = 5'd6; id_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_val("pre_rst_stall_cnt", 32'(stall_cnt), 32'(exp_stall + 3));
    id_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("midrst_ex_valid", 32'(ex_valid), 32'd0);
    check_val("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_stall = 0;
    issue(4'b1100, 5'd6, 5'd0, 5'd0, 5'd0, 1'b0, -1, 5'd0, stalls, cnt_wb);
    check_val("post_rst_stalls", 32'(stalls), 32'd0);
    check_val("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
